// File: rtl/acq_pkg.sv
// Shared types and helpers for the video acquisition core.
package acq_pkg;

  // Frame tracking states, exposed on the top-level debug port.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PORCH  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DONE   = 2'd3
  } acq_state_t;

  // Bits needed to hold any value in 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int WIDTH = 8,
  parameter int MAX   = 255
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] r_cnt;

  // Count register: clear to 0, otherwise step up and stick at MAX.
  always_ff @(posedge clk) begin
    if (RST) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt < MAX_V)) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign q = r_cnt;

endmodule

// File: rtl/video_acq.sv
// Video acquisition core: tracks line/sample position from sync pulses and
// sample strobes, emits one registered pixel word per visible sample, and
// measures lines per frame to report sync lock.
//
// Handshake: pixel_valid is a one-cycle qualifier for pixel_out/pixel_x/
// pixel_y/frame_start; there is no ready, the consumer takes every pulse.
module video_acq
  import acq_pkg::*;
#(
  parameter int NB_CHANNELS  = 4,
  parameter int NB_LINES     = 200,
  parameter int NB_COLS      = 640,
  parameter int V_BACK_PORCH = 21,
  parameter int H_BACK_PORCH = 110,
  parameter int MAX_LINES    = 512
) (
  input  logic                           clk,
  input  logic                           RST,
  input  logic                           enable,
  input  logic [NB_CHANNELS-1:0]         data_in,
  input  logic                           sampleValid,
  input  logic                           hSync,
  input  logic                           vSync,
  output logic [NB_CHANNELS-1:0]         pixel_out,
  output logic [$clog2(NB_COLS)-1:0]     pixel_x,
  output logic [$clog2(NB_LINES)-1:0]    pixel_y,
  output logic                           pixel_valid,
  output logic                           frame_start,
  output logic                           activeVideo,
  output logic [$clog2(MAX_LINES+1)-1:0] frame_lines,
  output logic                           locked,
  output logic [1:0]                     state_dbg
);

  localparam int XW   = $clog2(NB_COLS);
  localparam int YW   = $clog2(NB_LINES);
  localparam int FLW  = $clog2(MAX_LINES + 1);
  localparam int HMAX = H_BACK_PORCH + NB_COLS;
  localparam int HW   = cnt_w(HMAX);
  localparam int VW   = cnt_w(MAX_LINES);

  localparam logic [HW-1:0] H_FIRST = HW'(H_BACK_PORCH);
  localparam logic [HW-1:0] H_END   = HW'(HMAX);
  localparam logic [VW-1:0] V_FIRST = VW'(V_BACK_PORCH);
  localparam logic [VW-1:0] V_END   = VW'(V_BACK_PORCH + NB_LINES);

  acq_state_t r_state;
  acq_state_t w_state_nxt;

  logic [HW-1:0]          w_hcnt;
  logic [VW-1:0]          w_vcnt;
  logic                   w_active;
  logic                   w_capture;
  logic                   w_origin;

  logic [NB_CHANNELS-1:0] r_pixel_out;
  logic [XW-1:0]          r_pixel_x;
  logic [YW-1:0]          r_pixel_y;
  logic                   r_pixel_valid;
  logic                   r_frame_start;
  logic [FLW-1:0]         r_frame_lines;
  logic                   r_locked;

  // Sample position within the line; hSync beats a coincident strobe.
  sat_counter #(.WIDTH(HW), .MAX(HMAX)) u_hcnt (
    .clk (clk),
    .RST (RST),
    .clr (enable & hSync),
    .inc (enable & sampleValid),
    .q   (w_hcnt)
  );

  // Line position within the frame; vSync beats a coincident hSync.
  sat_counter #(.WIDTH(VW), .MAX(MAX_LINES)) u_vcnt (
    .clk (clk),
    .RST (RST),
    .clr (enable & vSync),
    .inc (enable & hSync),
    .q   (w_vcnt)
  );

  // Frame state register.
  always_ff @(posedge clk) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: disable forces IDLE, any vSync outside IDLE restarts.
  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (vSync) w_state_nxt = ST_PORCH;
        ST_PORCH:  if (vSync) w_state_nxt = ST_PORCH;
                   else if (w_vcnt >= V_FIRST) w_state_nxt = ST_ACTIVE;
        ST_ACTIVE: if (vSync) w_state_nxt = ST_PORCH;
                   else if (w_vcnt >= V_END) w_state_nxt = ST_DONE;
        ST_DONE:   if (vSync) w_state_nxt = ST_PORCH;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign w_active  = (r_state == ST_ACTIVE) && (w_hcnt >= H_FIRST) && (w_hcnt < H_END);
  assign w_capture = enable & sampleValid & w_active & ~hSync;
  assign w_origin  = (w_hcnt == H_FIRST) && (w_vcnt == V_FIRST);

  // Pixel output register: one pulse per captured strobe, coordinates held between pulses.
  always_ff @(posedge clk) begin
    if (RST) begin
      r_pixel_valid <= 1'b0;
      r_frame_start <= 1'b0;
      r_pixel_out   <= '0;
      r_pixel_x     <= '0;
      r_pixel_y     <= '0;
    end else begin
      r_pixel_valid <= w_capture;
      r_frame_start <= w_capture & w_origin;
      if (w_capture) begin
        r_pixel_out <= data_in;
        r_pixel_x   <= XW'(w_hcnt - H_FIRST);
        r_pixel_y   <= YW'(w_vcnt - V_FIRST);
      end
    end
  end

  // Frame length and lock: only a vSync that closes a tracked frame updates them.
  always_ff @(posedge clk) begin
    if (RST) begin
      r_frame_lines <= '0;
      r_locked      <= 1'b0;
    end else if (!enable) begin
      r_locked <= 1'b0;
    end else if (vSync && (r_state != ST_IDLE)) begin
      r_frame_lines <= FLW'(w_vcnt);
      r_locked      <= (FLW'(w_vcnt) == r_frame_lines);
    end
  end

  assign pixel_out   = r_pixel_out;
  assign pixel_x     = r_pixel_x;
  assign pixel_y     = r_pixel_y;
  assign pixel_valid = r_pixel_valid;
  assign frame_start = r_frame_start;
  assign activeVideo = w_active;
  assign frame_lines = r_frame_lines;
  assign locked      = r_locked;
  assign state_dbg   = r_state;

endmodule
